// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and baud divisor helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Reloadable bit-period down-counter; bit_end marks the last cycle of a bit.
// Module name kept as uart_baud_tick so the receiver can instantiate it unchanged.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = run && (cnt == '0);

  // Reload on terminal count so every bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (run) begin
      if (bit_end) cnt <= RELOAD;
      else         cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one byte per request, LSB first, optional parity.
//   state  | meaning
//   IDLE   | line high, waiting for new_tx_data
//   START  | driving start bit (0)
//   DATA   | shifting out 8 data bits, LSB first
//   PARITY | driving parity bit (only when PARITY != 0)
//   STOP   | driving STOP_BITS stop bits (1), then tx_done
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = uart_pkg::PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  localparam logic HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic LAST_STOP  = (STOP_BITS == 2);

  logic [2:0] state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       par_bit;
  logic       accept;
  logic       bit_end;

  assign accept = (state == S_IDLE) && new_tx_data;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .run    (state != S_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (new_tx_data) begin
            shreg   <= tx_data;
            par_bit <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (HAS_PARITY) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          // Busy drops on the same edge that ends the last stop bit; the
          // earliest next accept is therefore one edge later.
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover no/odd/even parity
// at 4 clocks per bit and the default 434-clock configuration.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data_v [4];
  logic [3:0] new_tx = 4'b0000;

  logic busy0, busy1, busy2, busy3;
  logic txl0, txl1, txl2, txl3;
  logic done0, done1, done2, done3;
  logic [3:0] busy_v, tx_v, done_v;

  assign busy_v = {busy3, busy2, busy1, busy0};
  assign tx_v   = {txl3, txl2, txl1, txl0};
  assign done_v = {done3, done2, done1, done0};

  int n_cmp = 0;
  int n_err = 0;

  logic cap_tx[$];
  logic cap_busy[$];
  logic cap_done[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[0]), .new_tx_data(new_tx[0]),
    .tx_busy(busy0), .tx(txl0), .tx_done(done0));
  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[1]), .new_tx_data(new_tx[1]),
    .tx_busy(busy1), .tx(txl1), .tx_done(done1));
  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .PARITY(2), .STOP_BITS(1)) u_p2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[2]), .new_tx_data(new_tx[2]),
    .tx_busy(busy2), .tx(txl2), .tx_done(done2));
  uart_tx_serializer u_def (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[3]), .new_tx_data(new_tx[3]),
    .tx_busy(busy3), .tx(txl3), .tx_done(done3));

  // Request is held across exactly one rising edge (the accepting one).
  task automatic pulse(input int u, input logic [7:0] b);
    @(negedge clk);
    tx_data_v[u] = b;
    new_tx[u] = 1'b1;
    @(posedge clk);
    #1;
    new_tx[u] = 1'b0;
  endtask

  // Sample ncyc negedges; sample 0 is the first cycle after the accepting edge.
  // Optionally raise a one-cycle request right after sample inj.
  task automatic capture(input int u, input int ncyc, input int inj, input logic [7:0] inj_b);
    cap_tx.delete();
    cap_busy.delete();
    cap_done.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cap_tx.push_back(tx_v[u]);
      cap_busy.push_back(busy_v[u]);
      cap_done.push_back(done_v[u]);
      if (i == inj + 1) new_tx[u] = 1'b0;
      if (i == inj) begin
        tx_data_v[u] = inj_b;
        new_tx[u] = 1'b1;
      end
    end
    new_tx[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_v !== 4'hF) begin n_err++; $display("FAIL reset_tx: got %b want 1111", tx_v); end
    n_cmp++; if (busy_v !== 4'h0) begin n_err++; $display("FAIL reset_busy: got %b want 0000", busy_v); end
    n_cmp++; if (done_v !== 4'h0) begin n_err++; $display("FAIL reset_done: got %b want 0000", done_v); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    pulse(0, 8'h00);
    capture(0, 8, -1, 8'h00);
    n_cmp++; if (cap_tx[7] !== 1'b0 || cap_busy[7] !== 1'b1)
      begin n_err++; $display("FAIL midreset_setup: tx=%b busy=%b want tx=0 busy=1", cap_tx[7], cap_busy[7]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (txl0 !== 1'b1) begin n_err++; $display("FAIL midreset_tx_async: got %b want 1", txl0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL midreset_busy_async: got %b want 0", busy0); end
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 40, -1, 8'h00);
    bad = 0;
    foreach (cap_tx[i]) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midreset_idle_after: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_single_byte();
    logic [11:0] exp;
    int errs, busy_len, done_cnt;
    exp = 12'b00_1101001010;
    pulse(0, 8'hA5);
    capture(0, 44, -1, 8'h00);
    n_cmp++; if (cap_busy[0] !== 1'b1) begin n_err++; $display("FAIL single_busy_next: got %b want 1", cap_busy[0]); end
    for (int j = 0; j < 10; j++) begin
      errs = 0;
      for (int c = 0; c < 4; c++) if (cap_tx[j*4+c] !== exp[j]) errs++;
      n_cmp++; if (errs != 0) begin n_err++; $display("FAIL single_bit%0d: got %0d wrong cycles want 0 (level %b)", j, errs, exp[j]); end
    end
    busy_len = 0; done_cnt = 0;
    foreach (cap_busy[i]) begin
      if (cap_busy[i] === 1'b1) busy_len++;
      if (cap_done[i] === 1'b1) done_cnt++;
    end
    n_cmp++; if (busy_len != 40) begin n_err++; $display("FAIL single_busy_len: got %0d want 40", busy_len); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (cap_done[40] !== 1'b1) begin n_err++; $display("FAIL single_done_pos: got %b want 1 at cycle 40", cap_done[40]); end
    n_cmp++; if (cap_tx[40] !== 1'b1) begin n_err++; $display("FAIL single_idle_tx: got %b want 1", cap_tx[40]); end
  endtask

  task automatic test_parity_odd();
    logic [11:0] exp;
    int errs, busy_len;
    exp = 12'b0_10000001110;
    pulse(1, 8'h07);
    capture(1, 48, -1, 8'h00);
    for (int j = 0; j < 11; j++) begin
      errs = 0;
      for (int c = 0; c < 4; c++) if (cap_tx[j*4+c] !== exp[j]) errs++;
      n_cmp++; if (errs != 0) begin n_err++; $display("FAIL odd_bit%0d: got %0d wrong cycles want 0 (level %b)", j, errs, exp[j]); end
    end
    busy_len = 0;
    foreach (cap_busy[i]) if (cap_busy[i] === 1'b1) busy_len++;
    n_cmp++; if (busy_len != 44) begin n_err++; $display("FAIL odd_busy_len: got %0d want 44", busy_len); end
  endtask

  task automatic test_parity_even();
    logic [11:0] exp;
    int errs, busy_len;
    exp = 12'b0_11000001110;
    pulse(2, 8'h07);
    capture(2, 48, -1, 8'h00);
    errs = 0;
    for (int c = 0; c < 4; c++) if (cap_tx[36+c] !== 1'b1) errs++;
    n_cmp++; if (errs != 0) begin n_err++; $display("FAIL even_parity_bit: got %0d wrong cycles want 0 (level 1)", errs); end
    errs = 0;
    for (int i = 0; i < 44; i++) if (cap_tx[i] !== exp[i/4]) errs++;
    n_cmp++; if (errs != 0) begin n_err++; $display("FAIL even_frame: got %0d wrong cycles want 0", errs); end
    busy_len = 0;
    foreach (cap_busy[i]) if (cap_busy[i] === 1'b1) busy_len++;
    n_cmp++; if (busy_len != 44) begin n_err++; $display("FAIL even_busy_len: got %0d want 44", busy_len); end
  endtask

  task automatic test_request_while_busy();
    logic [11:0] exp;
    int errs, tail_bad, done_cnt;
    exp = 12'b00_1000100010;
    pulse(0, 8'h11);
    capture(0, 64, 9, 8'h22);
    errs = 0;
    for (int i = 0; i < 40; i++) if (cap_tx[i] !== exp[i/4]) errs++;
    n_cmp++; if (errs != 0) begin n_err++; $display("FAIL busyreq_frame: got %0d wrong cycles want 0", errs); end
    tail_bad = 0; done_cnt = 0;
    for (int i = 40; i < 64; i++) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) tail_bad++;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) done_cnt++;
    n_cmp++; if (tail_bad != 0) begin n_err++; $display("FAIL busyreq_no_second: got %0d active cycles want 0", tail_bad); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL busyreq_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_busy_edge_request();
    int tail_bad;
    pulse(0, 8'h5A);
    // request is held only across the edge where busy falls
    capture(0, 56, 39, 8'h99);
    n_cmp++; if (cap_busy[40] !== 1'b0) begin n_err++; $display("FAIL edgereq_busy_fall: got %b want 0", cap_busy[40]); end
    tail_bad = 0;
    for (int i = 40; i < 56; i++) if (cap_busy[i] !== 1'b0 || cap_tx[i] !== 1'b1) tail_bad++;
    n_cmp++; if (tail_bad != 0) begin n_err++; $display("FAIL edgereq_not_accepted: got %0d active cycles want 0", tail_bad); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_a, exp_b;
    int errs_a, errs_b, done_cnt;
    exp_a = 12'b00_1001111000;
    exp_b = 12'b00_1001111010;
    pulse(0, 8'h3C);
    capture(0, 84, 40, 8'h3D);
    n_cmp++; if (cap_busy[1] !== 1'b1) begin n_err++; $display("FAIL b2b_busy_req1: got %b want 1", cap_busy[1]); end
    n_cmp++; if (cap_busy[40] !== 1'b0 || cap_tx[40] !== 1'b1)
      begin n_err++; $display("FAIL b2b_idle_gap: busy=%b tx=%b want busy=0 tx=1", cap_busy[40], cap_tx[40]); end
    n_cmp++; if (cap_busy[42] !== 1'b1) begin n_err++; $display("FAIL b2b_busy_req2: got %b want 1", cap_busy[42]); end
    errs_a = 0; errs_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (cap_tx[i] !== exp_a[i/4]) errs_a++;
      if (cap_tx[41+i] !== exp_b[i/4]) errs_b++;
    end
    n_cmp++; if (errs_a != 0) begin n_err++; $display("FAIL b2b_frame1: got %0d wrong cycles want 0", errs_a); end
    n_cmp++; if (errs_b != 0) begin n_err++; $display("FAIL b2b_frame2: got %0d wrong cycles want 0", errs_b); end
    done_cnt = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) done_cnt++;
    n_cmp++; if (done_cnt != 2) begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
  endtask

  task automatic test_default_params();
    logic [11:0] exp;
    int errs, busy_len;
    exp = 12'b00_1010101010;
    pulse(3, 8'h55);
    capture(3, 4345, -1, 8'h00);
    for (int j = 0; j < 10; j++) begin
      errs = 0;
      for (int c = 0; c < 434; c++) if (cap_tx[j*434+c] !== exp[j]) errs++;
      n_cmp++; if (errs != 0) begin n_err++; $display("FAIL default_bit%0d: got %0d wrong cycles want 0 (level %b)", j, errs, exp[j]); end
    end
    busy_len = 0;
    foreach (cap_busy[i]) if (cap_busy[i] === 1'b1) busy_len++;
    n_cmp++; if (busy_len != 4340) begin n_err++; $display("FAIL default_busy_len: got %0d want 4340", busy_len); end
    n_cmp++; if (cap_done[4340] !== 1'b1) begin n_err++; $display("FAIL default_done_pos: got %b want 1", cap_done[4340]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tx_data_v[i] = 8'h00;
    test_reset();
    test_reset_mid_frame();
    test_single_byte();
    test_parity_odd();
    test_parity_even();
    test_request_while_busy();
    test_busy_edge_request();
    test_back_to_back();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
